// File: rtl/mem_access_stage.sv
// MIPS MEM stage: a word-addressed data RAM with configurable access latency and the
// MEM/WB register. stall_mem holds the upstream pipeline while a multi-cycle access runs.
module mem_access_stage #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWriteM,
  input  logic                  MemtoRegM,
  input  logic                  MemWriteM,
  input  logic [DATA_WIDTH-1:0] alu_resultM,
  input  logic [DATA_WIDTH-1:0] write_dataM,
  input  logic [4:0]            write_regM,
  output logic                  stall_mem,
  output logic                  RegWriteW,
  output logic                  MemtoRegW,
  output logic [DATA_WIDTH-1:0] read_dataW,
  output logic [DATA_WIDTH-1:0] alu_resultW,
  output logic [4:0]            write_regW,
  output logic                  mem_faultW
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam int unsigned CntW  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'((MEM_LATENCY > 1) ? MEM_LATENCY - 2 : 0);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              mem_op;
  logic              misaligned;
  logic              complete;
  logic [ADDR_WIDTH-1:0] idx;

  logic [DATA_WIDTH-1:0] mem [Depth];

  // Upper address bits are dropped so accesses wrap around the RAM.
  assign idx        = alu_resultM[ADDR_WIDTH+1:2];
  assign mem_op     = MemtoRegM | MemWriteM;
  assign misaligned = mem_op & (alu_resultM[1:0] != 2'b00);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_mem = 1'b0;
    complete  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mem_op && (MEM_LATENCY > 1)) begin
          stall_mem = 1'b1;
          cnt_d     = CntInit;
          state_d   = StBusy;
        end else begin
          complete = 1'b1;
        end
      end
      StBusy: begin
        if (cnt_q != '0) begin
          stall_mem = 1'b1;
          cnt_d     = cnt_q - 1'b1;
        end else begin
          complete = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // RAM is not reset; a store on a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (!rst && complete && MemWriteM && !misaligned) begin
      mem[idx] <= write_dataM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      RegWriteW   <= 1'b0;
      MemtoRegW   <= 1'b0;
      mem_faultW  <= 1'b0;
      read_dataW  <= '0;
      alu_resultW <= '0;
      write_regW  <= '0;
    end else if (complete) begin
      RegWriteW   <= RegWriteM & ~misaligned;
      MemtoRegW   <= MemtoRegM;
      mem_faultW  <= misaligned;
      read_dataW  <= misaligned ? '0 : mem[idx];
      alu_resultW <= alu_resultM;
      write_regW  <= write_regM;
    end else begin
      // Stall edge: bubble into W, data fields hold.
      RegWriteW  <= 1'b0;
      MemtoRegW  <= 1'b0;
      mem_faultW <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: three instances (latency 1, 2, 4) with directed sequences
// and a table of single-cycle vectors on the latency-1 instance.
module tb_mem_access_stage;

  typedef struct packed {
    logic        rw;
    logic        m2r;
    logic        mw;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  wr;
  } min_t;

  typedef struct packed {
    logic        stall;
    logic        rw;
    logic        m2r;
    logic        fault;
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  wr;
  } wout_t;

  typedef struct {
    min_t        in;
    logic        chk_rd;
    logic [31:0] rd;
    logic        rw;
    logic        m2r;
    logic        fault;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  min_t  min1 = '0, min2 = '0, min4 = '0;
  wout_t o1, o2, o4;

  logic        s1, rw1, m2r1, f1;
  logic [31:0] rd1, alu1;
  logic [4:0]  wr1;
  logic        s2, rw2, m2r2, f2;
  logic [31:0] rd2, alu2;
  logic [4:0]  wr2;
  logic        s4, rw4, m2r4, f4;
  logic [31:0] rd4, alu4;
  logic [4:0]  wr4;

  always #5 clk = ~clk;

  mem_access_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .MEM_LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst),
    .RegWriteM(min1.rw), .MemtoRegM(min1.m2r), .MemWriteM(min1.mw),
    .alu_resultM(min1.alu), .write_dataM(min1.wd), .write_regM(min1.wr),
    .stall_mem(s1), .RegWriteW(rw1), .MemtoRegW(m2r1), .read_dataW(rd1),
    .alu_resultW(alu1), .write_regW(wr1), .mem_faultW(f1)
  );

  mem_access_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .MEM_LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst),
    .RegWriteM(min2.rw), .MemtoRegM(min2.m2r), .MemWriteM(min2.mw),
    .alu_resultM(min2.alu), .write_dataM(min2.wd), .write_regM(min2.wr),
    .stall_mem(s2), .RegWriteW(rw2), .MemtoRegW(m2r2), .read_dataW(rd2),
    .alu_resultW(alu2), .write_regW(wr2), .mem_faultW(f2)
  );

  mem_access_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .MEM_LATENCY(4)) u_l4 (
    .clk(clk), .rst(rst),
    .RegWriteM(min4.rw), .MemtoRegM(min4.m2r), .MemWriteM(min4.mw),
    .alu_resultM(min4.alu), .write_dataM(min4.wd), .write_regM(min4.wr),
    .stall_mem(s4), .RegWriteW(rw4), .MemtoRegW(m2r4), .read_dataW(rd4),
    .alu_resultW(alu4), .write_regW(wr4), .mem_faultW(f4)
  );

  assign o1 = '{stall: s1, rw: rw1, m2r: m2r1, fault: f1, rd: rd1, alu: alu1, wr: wr1};
  assign o2 = '{stall: s2, rw: rw2, m2r: m2r2, fault: f2, rd: rd2, alu: alu2, wr: wr2};
  assign o4 = '{stall: s4, rw: rw4, m2r: m2r4, fault: f4, rd: rd4, alu: alu4, wr: wr4};

  function automatic min_t mk(input logic rw, input logic m2r, input logic mw,
                              input logic [31:0] alu, input logic [31:0] wd,
                              input logic [4:0] wr);
    min_t m;
    m.rw = rw; m.m2r = m2r; m.mw = mw; m.alu = alu; m.wd = wd; m.wr = wr;
    return m;
  endfunction

  function automatic wout_t get_out(input int sel);
    case (sel)
      1:       return o1;
      2:       return o2;
      default: return o4;
    endcase
  endfunction

  task automatic set_in(input int sel, input min_t m);
    case (sel)
      1:       min1 = m;
      2:       min2 = m;
      default: min4 = m;
    endcase
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an op, ride out its stall (bubble W each stall edge), then take the
  // completing edge. Returns the number of cycles stall_mem was seen high.
  task automatic run_op(input int sel, input min_t m, output int stalls);
    wout_t o;
    set_in(sel, m);
    #1;
    stalls = 0;
    for (int i = 0; i < 10; i++) begin
      o = get_out(sel);
      if (!o.stall) break;
      stalls++;
      tick();
      o = get_out(sel);
      check("bubble_rw", {31'b0, o.rw}, 32'd0);
    end
    tick();
  endtask

  vec_t  tbl[10];
  wout_t o;
  int    st;

  initial begin
    // Latency-1 vectors: each completes on the next edge, never stalls.
    tbl[0] = '{mk(0, 0, 1, 32'h3FC, 32'hCAFEF00D, 5'd0), 1'b0, 32'h0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{mk(1, 1, 0, 32'h3FC, 32'h0, 5'd3), 1'b1, 32'hCAFEF00D, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{mk(0, 0, 1, 32'h000, 32'h11112222, 5'd0), 1'b0, 32'h0, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{mk(1, 1, 0, 32'h400, 32'h0, 5'd4), 1'b1, 32'h11112222, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{mk(1, 0, 0, 32'h55, 32'h0, 5'd9), 1'b0, 32'h0, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{mk(1, 0, 1, 32'h3FE, 32'h00000BAD, 5'd1), 1'b1, 32'h0, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{mk(1, 1, 0, 32'h3FC, 32'h0, 5'd6), 1'b1, 32'hCAFEF00D, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{mk(1, 1, 0, 32'h001, 32'h0, 5'd7), 1'b1, 32'h0, 1'b0, 1'b1, 1'b1};
    tbl[8] = '{mk(1, 1, 1, 32'h3FC, 32'h0BADBEEF, 5'd8), 1'b1, 32'hCAFEF00D, 1'b1, 1'b1, 1'b0};
    tbl[9] = '{mk(1, 1, 0, 32'h3FC, 32'h0, 5'd10), 1'b1, 32'h0BADBEEF, 1'b1, 1'b1, 1'b0};

    // Reset state on all instances.
    rst = 1'b1;
    tick();
    tick();
    for (int s = 1; s <= 4; s = s * 2) begin
      o = get_out(s);
      check("rst_stall", {31'b0, o.stall}, 32'd0);
      check("rst_rw", {31'b0, o.rw}, 32'd0);
      check("rst_m2r", {31'b0, o.m2r}, 32'd0);
      check("rst_fault", {31'b0, o.fault}, 32'd0);
      check("rst_rd", o.rd, 32'd0);
      check("rst_alu", o.alu, 32'd0);
      check("rst_wr", {27'b0, o.wr}, 32'd0);
    end
    rst = 1'b0;

    // L=2: non-mem op forwards next cycle.
    set_in(2, mk(1, 0, 0, 32'h55, 32'h0, 5'd7));
    #1;
    check("l2_alu_stall", {31'b0, o2.stall}, 32'd0);
    tick();
    check("l2_alu_res", o2.alu, 32'h55);
    check("l2_alu_wr", {27'b0, o2.wr}, 32'd7);
    check("l2_alu_rw", {31'b0, o2.rw}, 32'd1);

    // L=2: store stalls exactly one cycle, then load returns it two cycles later.
    set_in(2, mk(0, 0, 1, 32'h10, 32'hDEADBEEF, 5'd0));
    #1;
    check("l2_st_stall0", {31'b0, o2.stall}, 32'd1);
    tick();
    check("l2_st_bubble", {31'b0, o2.rw}, 32'd0);
    check("l2_st_stall1", {31'b0, o2.stall}, 32'd0);
    tick();
    check("l2_st_alu", o2.alu, 32'h10);
    set_in(2, mk(1, 1, 0, 32'h10, 32'h0, 5'd2));
    #1;
    check("l2_ld_stall0", {31'b0, o2.stall}, 32'd1);
    tick();
    check("l2_ld_bubble_m2r", {31'b0, o2.m2r}, 32'd0);
    check("l2_ld_stall1", {31'b0, o2.stall}, 32'd0);
    tick();
    check("l2_ld_rd", o2.rd, 32'hDEADBEEF);
    check("l2_ld_m2r", {31'b0, o2.m2r}, 32'd1);
    check("l2_ld_rw", {31'b0, o2.rw}, 32'd1);
    check("l2_ld_wr", {27'b0, o2.wr}, 32'd2);
    set_in(2, '0);

    // L=4: store then load, three stall cycles each, single RegWriteW pulse.
    run_op(4, mk(0, 0, 1, 32'h10, 32'hDEADBEEF, 5'd0), st);
    check("l4_st_stalls", st, 32'd3);
    run_op(4, mk(1, 1, 0, 32'h10, 32'h0, 5'd5), st);
    check("l4_ld_stalls", st, 32'd3);
    check("l4_ld_rw", {31'b0, o4.rw}, 32'd1);
    check("l4_ld_rd", o4.rd, 32'hDEADBEEF);
    set_in(4, '0);
    tick();
    check("l4_ld_pulse_end", {31'b0, o4.rw}, 32'd0);

    // L=4: misaligned store faults and leaves the word alone.
    run_op(4, mk(1, 0, 1, 32'h12, 32'h0, 5'd6), st);
    check("l4_mis_stalls", st, 32'd3);
    check("l4_mis_fault", {31'b0, o4.fault}, 32'd1);
    check("l4_mis_rw", {31'b0, o4.rw}, 32'd0);
    check("l4_mis_rd", o4.rd, 32'd0);
    run_op(4, mk(1, 1, 0, 32'h10, 32'h0, 5'd5), st);
    check("l4_mis_keep", o4.rd, 32'hDEADBEEF);
    check("l4_mis_fault_clr", {31'b0, o4.fault}, 32'd0);

    // L=4: reset in the second busy cycle of a store discards it.
    set_in(4, mk(0, 0, 1, 32'h10, 32'h12345678, 5'd0));
    tick();
    tick();
    check("l4_rst_busy", {31'b0, o4.stall}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_in(4, '0);
    #1;
    check("l4_rst_stall", {31'b0, o4.stall}, 32'd0);
    check("l4_rst_alu", o4.alu, 32'd0);
    check("l4_rst_rd", o4.rd, 32'd0);
    check("l4_rst_rw", {31'b0, o4.rw}, 32'd0);
    run_op(4, mk(1, 1, 0, 32'h10, 32'h0, 5'd5), st);
    check("l4_rst_stalls", st, 32'd3);
    check("l4_rst_keep", o4.rd, 32'hDEADBEEF);

    // L=1 table.
    for (int i = 0; i < 10; i++) begin
      set_in(1, tbl[i].in);
      #1;
      check($sformatf("l1_v%0d_stall", i), {31'b0, o1.stall}, 32'd0);
      tick();
      check($sformatf("l1_v%0d_rw", i), {31'b0, o1.rw}, {31'b0, tbl[i].rw});
      check($sformatf("l1_v%0d_m2r", i), {31'b0, o1.m2r}, {31'b0, tbl[i].m2r});
      check($sformatf("l1_v%0d_fault", i), {31'b0, o1.fault}, {31'b0, tbl[i].fault});
      check($sformatf("l1_v%0d_alu", i), o1.alu, tbl[i].in.alu);
      check($sformatf("l1_v%0d_wr", i), {27'b0, o1.wr}, {27'b0, tbl[i].in.wr});
      if (tbl[i].chk_rd) check($sformatf("l1_v%0d_rd", i), o1.rd, tbl[i].rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
